cvxif_result_buffer: RTL and testbench

//  Downstream stage of the CVXIF posit coprocessor (PAU). Records {id, rd} of each accepted

---
 rtl/cvxif_result_buffer.sv | 116 +++++++++++
 tb/tb_cvxif_result_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_result_buffer.sv
// CVXIF result buffer: pairs PAU results with issue-order {id, rd} tags and returns them to the core in order.
// Optional CVXIF_RESBUF_NAR_EN: flag NaR results on core_exc and suppress their register write.
module cvxif_result_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned TAG_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tag_valid,
  output logic                         tag_ready,
  input  logic [ID_W-1:0]              tag_id,
  input  logic [4:0]                   tag_rd,
  input  logic                         pau_valid,
  output logic                         pau_ready,
  input  logic [DATA_W-1:0]            pau_data,
  output logic                         core_valid,
  input  logic                         core_ready,
  output logic [ID_W-1:0]              core_id,
  output logic [4:0]                   core_rd,
  output logic                         core_we,
  output logic [DATA_W-1:0]            core_data,
  output logic                         core_exc,
  output logic [$clog2(RES_DEPTH):0]   res_count
);

  localparam int unsigned TAG_AW = $clog2(TAG_DEPTH);
  localparam int unsigned RES_AW = $clog2(RES_DEPTH);

  logic [TAG_AW:0]   tag_wptr, tag_rptr;
  logic [RES_AW:0]   res_wptr, res_rptr;
  logic [ID_W-1:0]   tag_id_mem [TAG_DEPTH];
  logic [4:0]        tag_rd_mem [TAG_DEPTH];
  logic [ID_W-1:0]   res_id_mem [RES_DEPTH];
  logic [4:0]        res_rd_mem [RES_DEPTH];
  logic              res_we_mem [RES_DEPTH];
  logic [DATA_W-1:0] res_data_mem [RES_DEPTH];

  logic tag_empty, tag_full, res_empty, res_full;
  logic tag_push, pau_fire, core_fire;
  logic [TAG_AW-1:0] tag_head;
  logic [RES_AW-1:0] res_head, res_tail;
  logic              new_we;

  assign tag_empty = (tag_wptr == tag_rptr);
  assign tag_full  = (tag_wptr[TAG_AW] != tag_rptr[TAG_AW]) &&
                     (tag_wptr[TAG_AW-1:0] == tag_rptr[TAG_AW-1:0]);
  assign res_empty = (res_wptr == res_rptr);
  assign res_full  = (res_wptr[RES_AW] != res_rptr[RES_AW]) &&
                     (res_wptr[RES_AW-1:0] == res_rptr[RES_AW-1:0]);

  // Handshakes depend only on stored state, never on the partner's valid.
  assign tag_ready = !tag_full;
  assign pau_ready = !tag_empty && !res_full;
  assign tag_push  = tag_valid && tag_ready;
  assign pau_fire  = pau_valid && pau_ready;
  assign core_fire = core_valid && core_ready;

  assign tag_head  = tag_rptr[TAG_AW-1:0];
  assign res_head  = res_rptr[RES_AW-1:0];
  assign res_tail  = res_wptr[RES_AW-1:0];

`ifdef CVXIF_RESBUF_NAR_EN
  logic res_nar_mem [RES_DEPTH];
  logic new_nar;

  assign new_nar  = (pau_data == {1'b1, {(DATA_W-1){1'b0}}});
  assign new_we   = (tag_rd_mem[tag_head] != 5'd0) && !new_nar;
  assign core_exc = core_valid && res_nar_mem[res_head];

  always_ff @(posedge clk) begin
    if (pau_fire) res_nar_mem[res_tail] <= new_nar;
  end
`else
  assign new_we   = (tag_rd_mem[tag_head] != 5'd0);
  assign core_exc = 1'b0;
`endif

  // Pointer state; reset discards every outstanding tag and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wptr <= '0;
      tag_rptr <= '0;
      res_wptr <= '0;
      res_rptr <= '0;
    end else begin
      if (tag_push)  tag_wptr <= tag_wptr + (TAG_AW+1)'(1);
      if (pau_fire)  tag_rptr <= tag_rptr + (TAG_AW+1)'(1);
      if (pau_fire)  res_wptr <= res_wptr + (RES_AW+1)'(1);
      if (core_fire) res_rptr <= res_rptr + (RES_AW+1)'(1);
    end
  end

  // Storage arrays need no reset: they are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_id_mem[tag_wptr[TAG_AW-1:0]] <= tag_id;
      tag_rd_mem[tag_wptr[TAG_AW-1:0]] <= tag_rd;
    end
    if (pau_fire) begin
      res_id_mem[res_tail]   <= tag_id_mem[tag_head];
      res_rd_mem[res_tail]   <= tag_rd_mem[tag_head];
      res_we_mem[res_tail]   <= new_we;
      res_data_mem[res_tail] <= pau_data;
    end
  end

  assign core_valid = !res_empty;
  assign core_id    = core_valid ? res_id_mem[res_head]   : '0;
  assign core_rd    = core_valid ? res_rd_mem[res_head]   : 5'd0;
  assign core_we    = core_valid && res_we_mem[res_head];
  assign core_data  = core_valid ? res_data_mem[res_head] : '0;
  assign res_count  = res_wptr - res_rptr;

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Directed self-checking bench for cvxif_result_buffer (default parameters).
module tb_cvxif_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tag_valid, tag_ready;
  logic [3:0]  tag_id;
  logic [4:0]  tag_rd;
  logic        pau_valid, pau_ready;
  logic [31:0] pau_data;
  logic        core_valid, core_ready;
  logic [3:0]  core_id;
  logic [4:0]  core_rd;
  logic        core_we;
  logic [31:0] core_data;
  logic        core_exc;
  logic [2:0]  res_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cvxif_result_buffer dut (
    .clk(clk), .rst(rst),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_id(tag_id), .tag_rd(tag_rd),
    .pau_valid(pau_valid), .pau_ready(pau_ready), .pau_data(pau_data),
    .core_valid(core_valid), .core_ready(core_ready), .core_id(core_id), .core_rd(core_rd),
    .core_we(core_we), .core_data(core_data), .core_exc(core_exc), .res_count(res_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_tag(input logic [3:0] id, input logic [4:0] rd);
    tag_valid = 1'b1; tag_id = id; tag_rd = rd;
    step();
    tag_valid = 1'b0;
  endtask

  task automatic push_res(input logic [31:0] d);
    pau_valid = 1'b1; pau_data = d;
    step();
    pau_valid = 1'b0;
  endtask

  task automatic pop();
    core_ready = 1'b1;
    step();
    core_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tag_valid = 1'b0; tag_id = '0; tag_rd = '0;
    pau_valid = 1'b0; pau_data = '0; core_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_tag_ready", 64'(tag_ready), 64'd1);
    check("rst_pau_ready", 64'(pau_ready), 64'd0);
    check("rst_core_valid", 64'(core_valid), 64'd0);
    check("rst_core_id", 64'(core_id), 64'd0);
    check("rst_core_data", 64'(core_data), 64'd0);
    check("rst_core_we", 64'(core_we), 64'd0);
    check("rst_core_exc", 64'(core_exc), 64'd0);
    check("rst_res_count", 64'(res_count), 64'd0);

    // Single transaction
    push_tag(4'd3, 5'd5);
    settle();
    check("t1_pau_ready", 64'(pau_ready), 64'd1);
    push_res(32'h4000_0000);
    settle();
    check("t1_core_valid", 64'(core_valid), 64'd1);
    check("t1_core_id", 64'(core_id), 64'd3);
    check("t1_core_rd", 64'(core_rd), 64'd5);
    check("t1_core_we", 64'(core_we), 64'd1);
    check("t1_core_data", 64'(core_data), 64'h4000_0000);
    check("t1_res_count", 64'(res_count), 64'd1);
    step();
    check("t1_hold_id", 64'(core_id), 64'd3);
    check("t1_hold_data", 64'(core_data), 64'h4000_0000);
    pop();
    settle();
    check("t1_core_valid_after", 64'(core_valid), 64'd0);
    check("t1_res_count_after", 64'(res_count), 64'd0);
    check("t1_core_data_zero", 64'(core_data), 64'd0);

    // PAU valid without any tag must not be accepted
    pau_valid = 1'b1; pau_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("t2_pau_ready", 64'(pau_ready), 64'd0);
      check("t2_core_valid", 64'(core_valid), 64'd0);
      step();
    end
    pau_valid = 1'b0;

    // Fill tag FIFO, overflow ignored, fill result FIFO, drain in order
    for (int i = 0; i < 4; i++) push_tag(4'(i), 5'(i + 1));
    settle();
    check("t3_tag_full", 64'(tag_ready), 64'd0);
    push_tag(4'd9, 5'd9);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_pau_ready_fill", 64'(pau_ready), 64'd1);
      push_res(32'h100 + 32'(i));
    end
    settle();
    check("t3_res_count_full", 64'(res_count), 64'd4);
    check("t3_pau_ready_full", 64'(pau_ready), 64'd0);
    check("t3_tag_ready_empty", 64'(tag_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_order_id", 64'(core_id), 64'(i));
      check("t3_order_rd", 64'(core_rd), 64'(i + 1));
      check("t3_order_data", 64'(core_data), 64'h100 + 64'(i));
      pop();
    end
    settle();
    check("t3_drained", 64'(core_valid), 64'd0);
    check("t3_overflow_dropped", 64'(pau_ready), 64'd0);

    // Simultaneous push and pop keeps occupancy
    push_tag(4'd4, 5'd1);
    push_tag(4'd5, 5'd2);
    push_tag(4'd6, 5'd3);
    push_res(32'h200);
    push_res(32'h201);
    settle();
    check("t4_count_before", 64'(res_count), 64'd2);
    check("t4_head_before", 64'(core_id), 64'd4);
    check("t4_pau_ready", 64'(pau_ready), 64'd1);
    pau_valid = 1'b1; pau_data = 32'h202; core_ready = 1'b1;
    step();
    pau_valid = 1'b0; core_ready = 1'b0;
    settle();
    check("t4_count_same", 64'(res_count), 64'd2);
    check("t4_head_id", 64'(core_id), 64'd5);
    check("t4_head_data", 64'(core_data), 64'h201);
    pop();
    settle();
    check("t4_tail_id", 64'(core_id), 64'd6);
    check("t4_tail_data", 64'(core_data), 64'h202);
    pop();
    settle();
    check("t4_empty", 64'(res_count), 64'd0);

    // rd=0 write suppression and NaR handling
    push_tag(4'd1, 5'd0);
    push_res(32'h1234_5678);
    settle();
    check("t5_rd0_we", 64'(core_we), 64'd0);
    check("t5_rd0_data", 64'(core_data), 64'h1234_5678);
    check("t5_rd0_exc", 64'(core_exc), 64'd0);
    pop();
    push_tag(4'd2, 5'd7);
    push_res(32'h8000_0000);
    settle();
    check("t5_nar_id", 64'(core_id), 64'd2);
`ifdef CVXIF_RESBUF_NAR_EN
    check("t5_nar_exc", 64'(core_exc), 64'd1);
    check("t5_nar_we", 64'(core_we), 64'd0);
`else
    check("t5_nar_exc", 64'(core_exc), 64'd0);
    check("t5_nar_we", 64'(core_we), 64'd1);
`endif
    pop();

    // Reset in mid-operation discards everything
    for (int i = 0; i < 3; i++) push_tag(4'(8 + i), 5'(10 + i));
    for (int i = 0; i < 3; i++) push_res(32'h300 + 32'(i));
    settle();
    check("t6_count_pre", 64'(res_count), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("t6_core_valid", 64'(core_valid), 64'd0);
    check("t6_res_count", 64'(res_count), 64'd0);
    check("t6_tag_ready", 64'(tag_ready), 64'd1);
    check("t6_pau_ready", 64'(pau_ready), 64'd0);
    push_tag(4'hA, 5'd3);
    push_res(32'h55);
    settle();
    check("t6_new_valid", 64'(core_valid), 64'd1);
    check("t6_new_id", 64'(core_id), 64'hA);
    check("t6_new_rd", 64'(core_rd), 64'd3);
    check("t6_new_data", 64'(core_data), 64'h55);
    check("t6_new_count", 64'(res_count), 64'd1);
    pop();
    settle();
    check("t6_final_empty", 64'(core_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
